inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch/decode stage directly upstream of the reorder buffer. Fetches 32-bit words from the memory controller with a single-outstanding request/ack handshake and buffers them with their PCs in a small instruction queue. Decodes the queue head into the ROB issue fields and presents one instruction per cycle while the ROB is not full. Sequential PC+4 fetch; a commit-time redirect flushes the queue and restarts at the target.

## Interface
- `IQ_DEPTH`, 4: instruction queue entries; must be a power of two and at least 2.
- `RESET_PC`, 32'h0: PC after reset.

- `clk_in` in 1: clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `rdy_in` in 1: global enable; when low all state is frozen.
- `mem_req` out 1: fetch request, registered.
- `mem_addr` out 32: fetch address, registered, stable while `mem_req`=1.
- `mem_ack` in 1: one-cycle pulse, `mem_data` valid.
- `mem_data` in 32: fetched instruction word.
- `rob_full` in 1: ROB cannot accept an instruction this cycle.
- `jump_valid` in 1: redirect pulse from commit.
- `jump_pc` in 32: redirect target.
- `have_input` out 1: head instruction presented and consumed this cycle.
- `instr_input` out 32: raw instruction word.
- `instr_input_pc` out 32: its PC.
- `opcode_if` out 17: {instr[31:25], instr[14:12], instr[6:0]}.
- `rd_if` out 5: instr[11:7].
- `rs1_if` out 5: instr[19:15].
- `rs2_if` out 5: instr[24:20].
- `imm_if` out 32: sign-extended immediate.

## Operation
- Queue: circular buffer of {instr, pc}, head/tail pointers of log2(IQ_DEPTH) bits wrapping naturally, plus a count from 0 to IQ_DEPTH.
- Dispatch is combinational from the head: `have_input` = (count≠0) & !`rob_full` & !`jump_valid` & `rdy_in`. When `have_input`=1, the head pops at the clock edge.
- Fetch FSM:
  - IDLE: if count<IQ_DEPTH, set `mem_req`<=1, `mem_addr`<=pc, and go to WAIT.
  - WAIT: on `mem_ack`, set `mem_req`<=0, push {`mem_data`, pc}, set pc<=pc+4 (mod 2^32), and go to IDLE.
  - DROP: on `mem_ack`, set `mem_req`<=0, discard the data, and go to IDLE.
- Queue space is guaranteed at ack: no issue happens while in WAIT, and count cannot grow in WAIT.
- Push and pop in the same cycle leave count unchanged, including at full and when count=1.
- Redirect has priority over everything:
  - On `jump_valid`=1: count, head and tail <= 0, and pc <= `jump_pc`.
  - State IDLE stays IDLE; the new request uses `jump_pc` on the next edge.
  - State WAIT without ack goes to DROP. `mem_req` stays high until the ack arrives, and that data is discarded.
  - State WAIT with ack in the same cycle discards the data and goes to IDLE.
  - State DROP stays DROP with pc updated.
- Immediate decode by instr[6:0]:
  - I-type (0000011, 0010011, 1100111): sext(instr[31:20]).
  - S-type (0100011): sext({[31:25],[11:7]}).
  - B-type (1100011): sext({[31],[7],[30:25],[11:8],1'b0}).
  - U-type (0110111, 0010111): {[31:12],12'b0}.
  - J-type (1101111): sext({[31],[19:12],[20],[30:21],1'b0}).
  - Any other opcode: 0.
- Register fields are always the raw bit slices; the ROB ignores unused ones.
- `rdy_in`=0: no register changes and `have_input`=0. The memory controller does not pulse `mem_ack` while `rdy_in`=0.

## Timing
- Reset values (asynchronous, take effect immediately):
  - pc=RESET_PC, state=IDLE, count/head/tail=0.
  - `mem_req`=0, `mem_addr`=0.
  - `have_input`=0.
  - Queue contents are don't-care.
- First request: `mem_req`=1 one edge after reset release.
- Ack-to-presentation: data acked at edge N is presented with `have_input`=1 in cycle N+1, provided the queue was empty and `rob_full`=0.
- Request cadence: for a 1-cycle ack latency, at most one request every 2 cycles (issue edge, ack edge, then the next issue on the following edge).
- Redirect: the first request to `jump_pc` is issued at the edge after the redirect (from IDLE), or the edge after the dropped ack (from DROP).
- Reset asserted during WAIT/DROP: `mem_req` drops immediately. The memory controller shares `rst_in` and abandons the transaction.

## Test plan
- Reset with RESET_PC=0 and 1-cycle ack returning 0x00500093, 0x123452B7, 0xFE000CE3:
  - `mem_addr` sequence is 0, 4, 8.
  - Dispatch 1: `opcode_if`=17'h00013, rd=1, rs1=0, imm=5.
  - Dispatch 2: imm=0x12345000, rd=5.
  - Dispatch 3: `opcode_if`[6:0]=7'h63, imm=0xFFFFFFF8, pc=8.
- Hold `rob_full`=1 with IQ_DEPTH=4:
  - After 4 acks, `mem_req` stays 0 and `have_input`=0.
  - Release `rob_full`: 4 dispatches in consecutive cycles, in PC order 0..12, and refetch resumes at 16.
- At full with `rob_full`=0 and an ack landing on a pop edge: count stays 4 and no entry is lost or duplicated.
- Pulse `jump_valid` with `jump_pc`=0x100 during WAIT (ack 3 cycles later):
  - `have_input`=0 in the pulse cycle and the queue is empty afterward.
  - The acked word is never dispatched.
  - The next `mem_addr` is 0x100.
- Pulse `jump_valid` in the same cycle as `mem_ack`: the data is dropped, the state goes to IDLE, and the next `mem_addr`=`jump_pc`.
- Drop `rdy_in` for 5 cycles mid-stream: pc, count and `mem_req` are unchanged and there are no dispatches. Assert `rst_in` mid-WAIT: `mem_req`=0 in the same cycle.

Source files
------------

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: groups the fetch-stage bus signals.
//   master (fetch stage): drives mem_req/mem_addr and the dispatch fields;
//                         receives rdy_in, mem_ack/mem_data, rob_full, jump_valid/jump_pc.
//   slave  (environment): the opposite directions.
interface inst_fetch_if;
  logic        rdy_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        rob_full;
  logic        jump_valid;
  logic [31:0] jump_pc;
  logic        have_input;
  logic [31:0] instr_input;
  logic [31:0] instr_input_pc;
  logic [16:0] opcode_if;
  logic [4:0]  rd_if;
  logic [4:0]  rs1_if;
  logic [4:0]  rs2_if;
  logic [31:0] imm_if;

  modport master (
    input  rdy_in, mem_ack, mem_data, rob_full, jump_valid, jump_pc,
    output mem_req, mem_addr, have_input, instr_input, instr_input_pc,
           opcode_if, rd_if, rs1_if, rs2_if, imm_if
  );

  modport slave (
    output rdy_in, mem_ack, mem_data, rob_full, jump_valid, jump_pc,
    input  mem_req, mem_addr, have_input, instr_input, instr_input_pc,
           opcode_if, rd_if, rs1_if, rs2_if, imm_if
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch/decode stage feeding the reorder buffer.
// Fetches one word at a time from memory (single outstanding request),
// queues {instr, pc} in a small circular buffer and presents the decoded
// head to the ROB. A commit redirect flushes the queue and restarts fetch.
// Ports:
//   clk_in  - clock
//   rst_in  - asynchronous active-high reset
//   bus     - inst_fetch_if.master: memory request/ack, ROB dispatch fields,
//             redirect and global enable
module inst_fetch #(
  parameter int          IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  inst_fetch_if.master  bus
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [31:0]   pc_r, pc_s;
  logic          mem_req_r, mem_req_s;
  logic [31:0]   mem_addr_r, mem_addr_s;
  logic [PW-1:0] head_r, head_s;
  logic [PW-1:0] tail_r, tail_s;
  logic [CW-1:0] count_r, count_s;
  logic          push_s, pop_s, flush_s;
  logic [31:0]   head_instr_s;

  logic [31:0]   instr_mem_r [IQ_DEPTH];
  logic [31:0]   pc_mem_r    [IQ_DEPTH];

  // Sign-extended immediate selected by the major opcode.
  function automatic logic [31:0] imm_decode(input logic [31:0] instr);
    logic [31:0] imm;
    imm = 32'h0;
    case (instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        imm = {{20{instr[31]}}, instr[31:20]};
      7'b0100011:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      7'b1100011:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {instr[31:12], 12'h000};
      7'b1101111:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = 32'h0;
    endcase
    return imm;
  endfunction

  // Dispatch is combinational from the head; a redirect cycle never dispatches.
  assign pop_s = (count_r != {CW{1'b0}}) & ~bus.rob_full & ~bus.jump_valid & bus.rdy_in;
  assign head_instr_s = instr_mem_r[head_r];

  assign bus.have_input     = pop_s;
  assign bus.instr_input    = head_instr_s;
  assign bus.instr_input_pc = pc_mem_r[head_r];
  assign bus.opcode_if      = {head_instr_s[31:25], head_instr_s[14:12], head_instr_s[6:0]};
  assign bus.rd_if          = head_instr_s[11:7];
  assign bus.rs1_if         = head_instr_s[19:15];
  assign bus.rs2_if         = head_instr_s[24:20];
  assign bus.imm_if         = imm_decode(head_instr_s);
  assign bus.mem_req        = mem_req_r;
  assign bus.mem_addr       = mem_addr_r;

  // Fetch FSM next-state: redirect overrides normal sequencing; rdy_in low holds everything.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    mem_req_s  = mem_req_r;
    mem_addr_s = mem_addr_r;
    push_s     = 1'b0;
    flush_s    = 1'b0;
    if (bus.rdy_in) begin
      if (bus.jump_valid) begin
        flush_s = 1'b1;
        pc_s    = bus.jump_pc;
        case (state_r)
          ST_IDLE: begin
            // New request goes out on the following edge, already at jump_pc.
            state_s = ST_IDLE;
          end
          ST_WAIT, ST_DROP: begin
            // An in-flight word belongs to the old stream: finish it and discard.
            if (bus.mem_ack) begin
              mem_req_s = 1'b0;
              state_s   = ST_IDLE;
            end else begin
              state_s = ST_DROP;
            end
          end
          default: begin
            mem_req_s = 1'b0;
            state_s   = ST_IDLE;
          end
        endcase
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (count_r < DEPTH_C) begin
              mem_req_s  = 1'b1;
              mem_addr_s = pc_r;
              state_s    = ST_WAIT;
            end else begin
              state_s = ST_IDLE;
            end
          end
          ST_WAIT: begin
            // A slot is free here: it was free at issue and count cannot grow in WAIT.
            if (bus.mem_ack) begin
              mem_req_s = 1'b0;
              push_s    = 1'b1;
              pc_s      = pc_r + 32'd4;
              state_s   = ST_IDLE;
            end else begin
              state_s = ST_WAIT;
            end
          end
          ST_DROP: begin
            if (bus.mem_ack) begin
              mem_req_s = 1'b0;
              state_s   = ST_IDLE;
            end else begin
              state_s = ST_DROP;
            end
          end
          default: begin
            mem_req_s = 1'b0;
            state_s   = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // Queue pointer/occupancy next values; push and pop together keep count.
  always_comb begin
    head_s  = head_r;
    tail_s  = tail_r;
    count_s = count_r;
    if (flush_s) begin
      head_s  = {PW{1'b0}};
      tail_s  = {PW{1'b0}};
      count_s = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        head_s = head_r + PW'(1);
      end else begin
        head_s = head_r;
      end
      if (push_s) begin
        tail_s = tail_r + PW'(1);
      end else begin
        tail_s = tail_r;
      end
      count_s = count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
    end
  end

  // Control state registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_PC;
      mem_req_r  <= 1'b0;
      mem_addr_r <= 32'h0;
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      mem_req_r  <= mem_req_s;
      mem_addr_r <= mem_addr_s;
      head_r     <= head_s;
      tail_r     <= tail_s;
      count_r    <= count_s;
    end
  end

  // Queue storage; contents need no reset because count gates every read.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      instr_mem_r[tail_r] <= bus.mem_data;
      pc_mem_r[tail_r]    <= pc_r;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch. Expected dispatches and
// request addresses are queued by the stimulus; negedge monitors pop and
// compare whenever the DUT dispatches or raises a new memory request.
module tb_inst_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [16:0] opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  inst_fetch_if bus ();

  inst_fetch #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t        exp_disp [$];
  logic [31:0] exp_addr [$];
  int ack_lat   = 1;
  int acks_left = 0;
  logic prev_req = 1'b0;
  exp_t mon_e;
  logic [31:0] held_addr;
  logic        held_req;

  // Hand-decoded program image; other addresses hold addi x0,x0,addr[11:0].
  function automatic exp_t ref_entry(input logic [31:0] a);
    exp_t e;
    e.pc = a;
    case (a)
      32'h0:  begin e.instr = 32'h00500093; e.opc = 17'h00013; e.rd = 5'd1;  e.rs1 = 5'd0;  e.rs2 = 5'd5;  e.imm = 32'h00000005; end
      32'h4:  begin e.instr = 32'h123452B7; e.opc = 17'h026B7; e.rd = 5'd5;  e.rs1 = 5'd8;  e.rs2 = 5'd3;  e.imm = 32'h12345000; end
      32'h8:  begin e.instr = 32'hFE000CE3; e.opc = 17'h1FC63; e.rd = 5'd25; e.rs1 = 5'd0;  e.rs2 = 5'd0;  e.imm = 32'hFFFFFFF8; end
      32'hC:  begin e.instr = 32'h00512423; e.opc = 17'h00123; e.rd = 5'd8;  e.rs1 = 5'd2;  e.rs2 = 5'd5;  e.imm = 32'h00000008; end
      32'h10: begin e.instr = 32'hFF9FF0EF; e.opc = 17'h1FFEF; e.rd = 5'd1;  e.rs1 = 5'd31; e.rs2 = 5'd25; e.imm = 32'hFFFFFFF8; end
      default: begin
        e.instr = {a[11:0], 20'h00013};
        e.opc   = {a[11:5], 3'b000, 7'h13};
        e.rd    = 5'd0;
        e.rs1   = 5'd0;
        e.rs2   = a[4:0];
        e.imm   = {20'h0, a[11:0]};
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_run(input logic [31:0] first, input int n, input bit disp);
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(first + 32'(4 * k));
      if (disp) exp_disp.push_back(ref_entry(first + 32'(4 * k)));
    end
  endtask

  task automatic wait_drain(input int maxc);
    int c;
    c = 0;
    while ((exp_disp.size() != 0 || exp_addr.size() != 0) && c < maxc) begin
      step();
      c++;
    end
    n_checks++;
    if (exp_disp.size() != 0 || exp_addr.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d dispatches and %0d requests outstanding, expected 0",
               exp_disp.size(), exp_addr.size());
      exp_disp.delete();
      exp_addr.delete();
    end
  endtask

  // Reset takes effect immediately: outputs are checked 1 ns after assertion.
  task automatic do_reset();
    bus.jump_valid = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("rst_mem_req",    32'(bus.mem_req),    32'h0);
    chk("rst_mem_addr",   bus.mem_addr,        32'h0);
    chk("rst_have_input", 32'(bus.have_input), 32'h0);
    step();
    rst_in = 1'b0;
  endtask

  // Memory model: acks ack_lat cycles after seeing a request, while acks_left allows.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = 32'h0;
    forever begin
      @(posedge clk_in);
      #2;
      if (rst_in) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end else if (bus.rdy_in && bus.mem_req && acks_left > 0) begin
        wcnt++;
        if (wcnt >= ack_lat) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = ref_entry(bus.mem_addr).instr;
          acks_left--;
        end
      end
    end
  end

  // Dispatch monitor: every presented instruction must match the next expected one.
  always @(negedge clk_in) begin
    if (!rst_in && bus.have_input) begin
      if (exp_disp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dispatch: got pc 0x%08h, expected no dispatch", bus.instr_input_pc);
      end else begin
        mon_e = exp_disp.pop_front();
        chk("disp_pc",    bus.instr_input_pc, mon_e.pc);
        chk("disp_instr", bus.instr_input,    mon_e.instr);
        chk("disp_opc",   32'(bus.opcode_if), 32'(mon_e.opc));
        chk("disp_rd",    32'(bus.rd_if),     32'(mon_e.rd));
        chk("disp_rs1",   32'(bus.rs1_if),    32'(mon_e.rs1));
        chk("disp_rs2",   32'(bus.rs2_if),    32'(mon_e.rs2));
        chk("disp_imm",   bus.imm_if,         mon_e.imm);
      end
    end
  end

  // Request monitor: each new request is compared while expectations are queued.
  always @(negedge clk_in) begin
    if (!rst_in && bus.mem_req && !prev_req && exp_addr.size() != 0) begin
      chk("mem_addr_seq", bus.mem_addr, exp_addr.pop_front());
    end
    prev_req <= bus.mem_req & ~rst_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rdy_in     = 1'b1;
    bus.rob_full   = 1'b0;
    bus.jump_valid = 1'b0;
    bus.jump_pc    = 32'h0;
    step();

    // Basic stream: 0, 4, 8 decoded; first request and ack-to-presentation latency.
    ack_lat = 1; acks_left = 3;
    do_reset();
    expect_run(32'h0, 3, 1'b1);
    step();
    chk("first_req", 32'(bus.mem_req), 32'h1);
    step();
    #1;
    chk("ack_to_present", 32'(bus.have_input), 32'h1);
    wait_drain(40);

    // ROB full: queue fills, fetch stops, then 4 back-to-back dispatches and refetch at 16.
    bus.rob_full = 1'b1; ack_lat = 1; acks_left = 5;
    do_reset();
    expect_run(32'h0, 4, 1'b0);
    repeat (12) step();
    chk("full_no_req",  32'(bus.mem_req),    32'h0);
    chk("full_no_disp", 32'(bus.have_input), 32'h0);
    chk("full_reqs_seen", 32'(exp_addr.size()), 32'h0);
    for (int k = 0; k < 5; k++) exp_disp.push_back(ref_entry(32'(4 * k)));
    exp_addr.push_back(32'h10);
    bus.rob_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("consec_disp", 32'(bus.have_input), 32'h1);
      step();
    end
    wait_drain(40);

    // Redirect during WAIT: queued 0/4 and in-flight 8 are discarded, refetch at 0x100.
    bus.rob_full = 1'b1; ack_lat = 1; acks_left = 2;
    do_reset();
    expect_run(32'h0, 3, 1'b0);
    repeat (8) step();
    chk("pre_jump_wait", 32'(bus.mem_req), 32'h1);
    bus.jump_valid = 1'b1; bus.jump_pc = 32'h100; bus.rob_full = 1'b0;
    ack_lat = 3; acks_left = 3;
    expect_run(32'h100, 2, 1'b1);
    #1;
    chk("jump_blocks_disp", 32'(bus.have_input), 32'h0);
    step();
    bus.jump_valid = 1'b0;
    #1;
    chk("drop_queue_empty", 32'(bus.have_input), 32'h0);
    chk("drop_req_held",    32'(bus.mem_req),    32'h1);
    chk("drop_addr_held",   bus.mem_addr,        32'h8);
    wait_drain(60);

    // Redirect coinciding with ack: data dropped, IDLE, next request at jump_pc.
    ack_lat = 1; acks_left = 3;
    do_reset();
    exp_addr.push_back(32'h0);
    expect_run(32'h200, 2, 1'b1);
    step();
    chk("ackjump_req0", 32'(bus.mem_req), 32'h1);
    bus.jump_valid = 1'b1; bus.jump_pc = 32'h200;
    step();
    bus.jump_valid = 1'b0;
    chk("ackjump_idle", 32'(bus.mem_req), 32'h0);
    step();
    chk("ackjump_req",  32'(bus.mem_req), 32'h1);
    chk("ackjump_addr", bus.mem_addr,     32'h200);
    wait_drain(40);

    // Stream with rob_full toggling and a 5-cycle rdy_in freeze mid-stream.
    ack_lat = 1; acks_left = 8;
    do_reset();
    expect_run(32'h0, 8, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step();
      if (i >= 11 && i <= 15) begin
        chk("frz_mem_req",  32'(bus.mem_req), 32'(held_req));
        chk("frz_mem_addr", bus.mem_addr,     held_addr);
      end
      if (i == 10) begin
        held_req  = bus.mem_req;
        held_addr = bus.mem_addr;
        bus.rdy_in = 1'b0;
      end
      if (i == 15) bus.rdy_in = 1'b1;
      bus.rob_full = (i % 3 == 0);
      #1;
      if (!bus.rdy_in) chk("frz_no_disp", 32'(bus.have_input), 32'h0);
    end
    bus.rob_full = 1'b0;
    wait_drain(100);
    repeat (2) step();
    // Reset mid-WAIT: do_reset checks mem_req drops in the same cycle.
    chk("pre_rst_wait", 32'(bus.mem_req), 32'h1);
    do_reset();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
